// File: rtl/ddr2_rd_engine.sv
// MIG port-0 read engine: issues fixed-length read bursts while read mode is set
// and streams the returned words into the pipe-out FIFO without ever overrunning it.
module ddr2_rd_engine #(
    parameter int                  DATA_WIDTH    = 32,
    parameter int                  BURST_LEN     = 32,
    parameter int                  ADDR_WIDTH    = 30,
    parameter logic [ADDR_WIDTH-1:0] MEM_LAST_ADDR = 30'h03FF_FF80,
    parameter int                  OB_DEPTH      = 1024,
    parameter int                  OB_CNT_WIDTH  = 11
) (
    input  logic                    c1_clk0,
    input  logic                    c1_rst_n,
    input  logic                    calib_done,
    input  logic                    rd_mode,
    input  logic [OB_CNT_WIDTH-1:0] ob_count,
    output logic                    ob_wr_en,
    output logic [DATA_WIDTH-1:0]   ob_din,
    output logic                    p0_cmd_en,
    output logic [2:0]              p0_cmd_instr,
    output logic [5:0]              p0_cmd_bl,
    output logic [ADDR_WIDTH-1:0]   p0_cmd_byte_addr,
    input  logic                    p0_cmd_full,
    output logic                    p0_rd_en,
    input  logic [DATA_WIDTH-1:0]   p0_rd_data,
    input  logic                    p0_rd_empty,
    output logic                    busy,
    output logic [31:0]             words_read
);

    localparam int                    REM_W     = 7;
    localparam logic [ADDR_WIDTH-1:0]   ADDR_STEP = ADDR_WIDTH'(BURST_LEN * 4);
    localparam logic [OB_CNT_WIDTH-1:0] SPACE_LIM = OB_CNT_WIDTH'(OB_DEPTH - BURST_LEN);
    localparam logic [REM_W-1:0]        REM_LOAD  = REM_W'(BURST_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [REM_W-1:0]        r_remaining;
    logic                    r_cmd_en;
    logic [ADDR_WIDTH-1:0]   r_cmd_addr;
    logic                    r_ob_wr_en;
    logic [DATA_WIDTH-1:0]   r_ob_din;
    logic                    r_busy;
    logic [31:0]             r_words_read;
    logic                    w_rd_en;

    assign w_rd_en = (r_state == ST_DRAIN) && !p0_rd_empty;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (calib_done && rd_mode) w_state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (!rd_mode)
                    w_state_nxt = ST_IDLE;
                else if (ob_count <= SPACE_LIM && !p0_cmd_full)
                    w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: w_state_nxt = ST_DRAIN;
            // Leave only on the pop that consumes the final word of the burst
            ST_DRAIN: if (w_rd_en && r_remaining == REM_W'(1)) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge c1_clk0) begin
        if (!c1_rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_remaining  <= '0;
            r_cmd_en     <= 1'b0;
            r_cmd_addr   <= '0;
            r_ob_wr_en   <= 1'b0;
            r_ob_din     <= '0;
            r_busy       <= 1'b0;
            r_words_read <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cmd_en   <= (w_state_nxt == ST_ISSUE);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_ob_wr_en <= w_rd_en;
            if (w_rd_en)
                r_ob_din <= p0_rd_data;
            if (r_ob_wr_en)
                r_words_read <= r_words_read + 32'd1;
            if (w_state_nxt == ST_ISSUE)
                r_cmd_addr <= r_addr;
            // Sessions restart at 0; an in-flight burst always finishes before this applies
            if (r_state == ST_IDLE && !rd_mode)
                r_addr <= '0;
            if (r_state == ST_ISSUE) begin
                r_addr      <= (r_addr == MEM_LAST_ADDR) ? '0 : r_addr + ADDR_STEP;
                r_remaining <= REM_LOAD;
            end
            if (w_rd_en)
                r_remaining <= r_remaining - REM_W'(1);
        end
    end

    assign ob_wr_en         = r_ob_wr_en;
    assign ob_din           = r_ob_din;
    assign p0_cmd_en        = r_cmd_en;
    assign p0_cmd_instr     = 3'b001;
    assign p0_cmd_bl        = 6'(BURST_LEN - 1);
    assign p0_cmd_byte_addr = r_cmd_addr;
    assign p0_rd_en         = w_rd_en;
    assign busy             = r_busy;
    assign words_read       = r_words_read;

endmodule

// File: tb/tb_ddr2_rd_engine.sv
// Directed bench for ddr2_rd_engine: MIG read-port model plus scoreboard on the pipe-out writes.
module tb_ddr2_rd_engine;

    localparam int          DW    = 32;
    localparam int          BL    = 32;
    localparam int          AW    = 30;
    localparam logic [AW-1:0] LAST = 30'h100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          calib_done;
    logic          rd_mode;
    logic [10:0]   ob_count;
    logic          ob_wr_en;
    logic [DW-1:0] ob_din;
    logic          p0_cmd_en;
    logic [2:0]    p0_cmd_instr;
    logic [5:0]    p0_cmd_bl;
    logic [AW-1:0] p0_cmd_byte_addr;
    logic          p0_cmd_full;
    logic          p0_rd_en;
    logic [DW-1:0] p0_rd_data;
    logic          p0_rd_empty;
    logic          busy;
    logic [31:0]   words_read;

    always #5 clk = ~clk;

    ddr2_rd_engine #(
        .DATA_WIDTH(DW), .BURST_LEN(BL), .ADDR_WIDTH(AW), .MEM_LAST_ADDR(LAST),
        .OB_DEPTH(1024), .OB_CNT_WIDTH(11)
    ) dut (
        .c1_clk0(clk), .c1_rst_n(rst_n), .calib_done(calib_done), .rd_mode(rd_mode),
        .ob_count(ob_count), .ob_wr_en(ob_wr_en), .ob_din(ob_din),
        .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr), .p0_cmd_bl(p0_cmd_bl),
        .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_full(p0_cmd_full),
        .p0_rd_en(p0_rd_en), .p0_rd_data(p0_rd_data), .p0_rd_empty(p0_rd_empty),
        .busy(busy), .words_read(words_read)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // MIG read port model: each command queues BL words of an incrementing pattern
    logic [DW-1:0] mig_q[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] next_data = 32'h1000;
    logic          gap_en = 1'b0;
    logic          phase  = 1'b0;
    logic          pop_d  = 1'b0;
    int            pops   = 0;
    int            writes = 0;
    logic          mon_en = 1'b0;

    initial begin
        p0_rd_data  = '0;
        p0_rd_empty = 1'b1;
    end

    always @(posedge clk) begin
        pop_d = 1'b0;
        if (p0_rd_en && mig_q.size() > 0) begin
            pop_d = 1'b1;
            pops++;
            void'(mig_q.pop_front());
        end
        if (p0_cmd_en) begin
            for (int i = 0; i < BL; i++) begin
                mig_q.push_back(next_data);
                sb.push_back(next_data);
                next_data++;
            end
        end
        #1;
        phase       = ~phase;
        p0_rd_data  = (mig_q.size() > 0) ? mig_q[0] : '0;
        p0_rd_empty = (mig_q.size() == 0) || (gap_en && phase);
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("wr_latency", ob_wr_en, pop_d);
            chk("pop_while_empty", p0_rd_en & p0_rd_empty, 1'b0);
            if (ob_wr_en) begin
                writes++;
                if (sb.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
                else chk("ob_din", ob_din, sb.pop_front());
            end
        end
    end

    task automatic wait_cmd(output logic [AW-1:0] a, output int ncyc);
        ncyc = 0;
        a    = '1;
        do begin
            @(negedge clk);
            ncyc++;
        end while (!p0_cmd_en && ncyc < 300);
        if (!p0_cmd_en) chk("cmd_timeout", 1'b0, 1'b1);
        else a = p0_cmd_byte_addr;
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (writes < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", writes >= target, 1'b1);
    endtask

    task automatic hold_no_cmd(input string tag, input int cycles, input logic exp_busy);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen |= p0_cmd_en;
        end
        chk(tag, seen, 1'b0);
        chk({tag, "_busy"}, busy, exp_busy);
    endtask

    // rd_mode rises just after an edge; command must appear in the third cycle
    task automatic launch_check(input logic [AW-1:0] exp_addr);
        @(posedge clk); #1 rd_mode = 1'b1;
        @(negedge clk); chk("launch_c1_cmd", p0_cmd_en, 1'b0); chk("launch_c1_busy", busy, 1'b0);
        @(negedge clk); chk("launch_c2_cmd", p0_cmd_en, 1'b0); chk("launch_c2_busy", busy, 1'b1);
        @(negedge clk); chk("launch_c3_cmd", p0_cmd_en, 1'b1);
        chk("launch_addr", p0_cmd_byte_addr, exp_addr);
    endtask

    logic [AW-1:0] a;
    int            nc;

    initial begin
        rst_n       = 1'b0;
        rd_mode     = 1'b1;
        calib_done  = 1'b1;
        ob_count    = '0;
        p0_cmd_full = 1'b0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_ob_wr_en", ob_wr_en, 1'b0);
        chk("rst_ob_din", ob_din, 32'h0);
        chk("rst_cmd_en", p0_cmd_en, 1'b0);
        chk("rst_addr", p0_cmd_byte_addr, 30'h0);
        chk("rst_rd_en", p0_rd_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_words", words_read, 32'h0);
        chk("rst_instr", p0_cmd_instr, 3'b001);
        chk("rst_bl", p0_cmd_bl, 6'd31);
        rd_mode = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_cmd", p0_cmd_en, 1'b0);

        // Burst 1 at 0x0; then backpressure holds burst 2 in CHECK
        launch_check(30'h0);
        ob_count = 11'd993;
        wait_writes(32);
        chk("b1_last_din", ob_din, 32'h101F);
        hold_no_cmd("bp_ob_hold", 15, 1'b1);
        @(posedge clk); #1 ob_count = 11'd992;
        wait_cmd(a, nc);
        chk("bp_release_lat", nc, 2);
        chk("b2_addr", a, 30'h80);
        chk("b2_words_read", words_read, 32'd32);

        // Command FIFO full holds burst 3
        p0_cmd_full = 1'b1;
        wait_writes(64);
        hold_no_cmd("bp_full_hold", 15, 1'b1);
        @(posedge clk); #1 p0_cmd_full = 1'b0;
        gap_en = 1'b1;
        wait_cmd(a, nc);
        chk("b3_addr_last", a, LAST);
        wait_writes(96);
        gap_en = 1'b0;

        // Wrap back to 0, then drop rd_mode with 10 words outstanding
        wait_cmd(a, nc);
        chk("b4_addr_wrap", a, 30'h0);
        chk("b3_pops", pops, 96);
        chk("b4_words_read", words_read, 32'd96);
        nc = 0;
        while (pops < 118 && nc < 300) begin
            @(negedge clk);
            nc++;
        end
        chk("b4_pop22", pops, 118);
        rd_mode = 1'b0;
        nc = 0;
        do begin
            @(negedge clk);
            nc++;
        end while (busy && nc < 300);
        chk("b4_idle", busy, 1'b0);
        chk("b4_pops", pops, 128);
        repeat (2) @(negedge clk);
        chk("b4_writes", writes, 128);
        chk("b4_words_read_end", words_read, 32'd128);
        hold_no_cmd("off_hold", 10, 1'b0);

        // New session restarts at address 0
        launch_check(30'h0);
        rd_mode = 1'b0;
        wait_writes(160);
        repeat (3) @(negedge clk);
        chk("b5_idle", busy, 1'b0);
        chk("b5_words_read", words_read, 32'd160);
        chk("sb_empty", sb.size(), 0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
